// File: rtl/alu_writeback_if.sv
// ALU-result handshake bundle between the ALU (master) and the writeback stage (slave).
interface alu_writeback_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [5:0]            in_opcode;
    logic [2*DATA_W-1:0]   in_result;
    logic [ADDR_W-1:0]     in_rdst1;
    logic [ADDR_W-1:0]     in_rdst2;

    modport master (
        output in_valid, in_opcode, in_result, in_rdst1, in_rdst2,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_opcode, in_result, in_rdst1, in_rdst2,
        output in_ready
    );
endinterface

// File: rtl/alu_writeback.sv
// ALU writeback stage: filters opcodes, buffers results in a FIFO and sequences RF writes.
// Optional operand-forwarding outputs are enabled by defining ALU_WRITEBACK_FWD_EN.
module alu_writeback #(
    parameter int          DEPTH  = 2,
    parameter int          DATA_W = 16,
    parameter int          ADDR_W = 5,
    parameter logic [5:0]  MUL_OP = 6'b000111
) (
    input  logic                clock,
    input  logic                reset,
    alu_writeback_if.slave      in_bus,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_addr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic                busy,
    output logic [7:0]          drop_cnt
`ifdef ALU_WRITEBACK_FWD_EN
    ,
    output logic                fwd_valid,
    output logic [ADDR_W-1:0]   fwd_addr,
    output logic [DATA_W-1:0]   fwd_data
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {IDLE, WR_HI} state_t;

    function automatic logic is_legal(input logic [5:0] op);
        return (op == 6'd0) || (op == 6'd1) || ((op >= 6'd4) && (op <= 6'd16));
    endfunction

    function automatic logic ptr_full(input logic [PTR_W:0] wp, input logic [PTR_W:0] rp);
        return (wp[PTR_W] != rp[PTR_W]) && (wp[PTR_W-1:0] == rp[PTR_W-1:0]);
    endfunction

    logic                  mem_mul    [DEPTH];
    logic [2*DATA_W-1:0]   mem_result [DEPTH];
    logic [ADDR_W-1:0]     mem_rdst1  [DEPTH];
    logic [ADDR_W-1:0]     mem_rdst2  [DEPTH];

    logic [PTR_W:0]        wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [PTR_W-1:0]      head;
    logic                  empty, full, ready_q;
    logic                  accept, push, pop;

    state_t                state_q, state_d;
    logic                  we_d;
    logic [ADDR_W-1:0]     addr_d, hi_addr;
    logic [DATA_W-1:0]     wdata_d, hi_data;

    assign head   = rd_ptr[PTR_W-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = ptr_full(wr_ptr, rd_ptr);
    assign accept = in_bus.in_valid && ready_q;
    assign push   = accept && is_legal(in_bus.in_opcode);

    assign wr_ptr_nxt = wr_ptr + {{PTR_W{1'b0}}, push};
    assign rd_ptr_nxt = rd_ptr + {{PTR_W{1'b0}}, pop};

    // Ready is registered so the ALU never sees a combinational path from its own valid.
    assign in_bus.in_ready = ready_q;

    assign busy = !empty || (state_q == WR_HI) || rf_we;

    always_ff @(posedge clock) begin
        if (push) begin
            mem_mul[wr_ptr[PTR_W-1:0]]    <= (in_bus.in_opcode == MUL_OP);
            mem_result[wr_ptr[PTR_W-1:0]] <= in_bus.in_result;
            mem_rdst1[wr_ptr[PTR_W-1:0]]  <= in_bus.in_rdst1;
            mem_rdst2[wr_ptr[PTR_W-1:0]]  <= in_bus.in_rdst2;
        end
        if (pop) begin
            hi_addr <= mem_rdst2[head];
            hi_data <= mem_result[head][2*DATA_W-1:DATA_W];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ready_q  <= 1'b0;
            state_q  <= IDLE;
            rf_we    <= 1'b0;
            rf_addr  <= '0;
            rf_wdata <= '0;
            drop_cnt <= '0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            ready_q  <= !ptr_full(wr_ptr_nxt, rd_ptr_nxt);
            state_q  <= state_d;
            rf_we    <= we_d;
            rf_addr  <= addr_d;
            rf_wdata <= wdata_d;
            if (accept && !is_legal(in_bus.in_opcode) && (drop_cnt != 8'hFF))
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Low half is written on the pop cycle; a MUL spends one more cycle on the high half.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        we_d    = 1'b0;
        addr_d  = rf_addr;
        wdata_d = rf_wdata;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = mem_rdst1[head];
                    wdata_d = mem_result[head][DATA_W-1:0];
                    if (mem_mul[head])
                        state_d = WR_HI;
                end
            end
            WR_HI: begin
                we_d    = 1'b1;
                addr_d  = hi_addr;
                wdata_d = hi_data;
                state_d = IDLE;
            end
        endcase
    end

`ifdef ALU_WRITEBACK_FWD_EN
    logic fwd_hold;

    // rf_addr/rf_wdata hold after a write, so one extra cycle of valid exposes the last write.
    always_ff @(posedge clock) begin
        if (reset)
            fwd_hold <= 1'b0;
        else
            fwd_hold <= rf_we;
    end

    assign fwd_valid = rf_we || fwd_hold;
    assign fwd_addr  = rf_addr;
    assign fwd_data  = rf_wdata;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback (DEPTH=2), with forwarding checks when enabled.
module tb_alu_writeback;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;

    logic               clock;
    logic               reset;
    logic               rf_we;
    logic [ADDR_W-1:0]  rf_addr;
    logic [DATA_W-1:0]  rf_wdata;
    logic               busy;
    logic [7:0]         drop_cnt;
`ifdef ALU_WRITEBACK_FWD_EN
    logic               fwd_valid;
    logic [ADDR_W-1:0]  fwd_addr;
    logic [DATA_W-1:0]  fwd_data;
`endif

    int tests = 0;
    int fails = 0;

    alu_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    alu_writeback #(.DEPTH(2), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MUL_OP(6'b000111)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_bus   (bus.slave),
        .rf_we    (rf_we),
        .rf_addr  (rf_addr),
        .rf_wdata (rf_wdata),
        .busy     (busy),
        .drop_cnt (drop_cnt)
`ifdef ALU_WRITEBACK_FWD_EN
        ,
        .fwd_valid(fwd_valid),
        .fwd_addr (fwd_addr),
        .fwd_data (fwd_data)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] res,
                         input logic [4:0] r1, input logic [4:0] r2);
        bus.in_valid  = v;
        bus.in_opcode = op;
        bus.in_result = res;
        bus.in_rdst1  = r1;
        bus.in_rdst2  = r2;
    endtask

    task automatic check_wr(input string tag, input logic [4:0] a, input logic [15:0] d);
        check({tag, "_we"}, rf_we, 1);
        check({tag, "_addr"}, rf_addr, a);
        check({tag, "_data"}, rf_wdata, d);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 6'd0, 32'd0, 5'd0, 5'd0);
        @(negedge clock);
        step();
        check("rst_we", rf_we, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_addr", rf_addr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_ready", bus.in_ready, 0);
        reset = 1'b0;
        step();
        check("rel_ready", bus.in_ready, 1);

        // ADD -> single write one cycle after transfer
        drive(1'b1, 6'b000100, 32'h0000_1234, 5'd3, 5'd0);
        step();
        drive(1'b0, 6'd0, 32'd0, 5'd0, 5'd0);
        check("add_nowe_e0", rf_we, 0);
        check("add_busy_e0", busy, 1);
        step();
        check_wr("add", 5'd3, 16'h1234);
        step();
        check("add_we_off", rf_we, 0);
        check("add_busy_off", busy, 0);
        check("add_addr_hold", rf_addr, 3);
        check("add_data_hold", rf_wdata, 16'h1234);

        // MUL -> lo then hi
        drive(1'b1, 6'b000111, 32'hABCD_5678, 5'd4, 5'd5);
        step();
        drive(1'b0, 6'd0, 32'd0, 5'd0, 5'd0);
        step();
        check_wr("mul_lo", 5'd4, 16'h5678);
        step();
        check_wr("mul_hi", 5'd5, 16'hABCD);
        step();
        check("mul_we_off", rf_we, 0);
        check("mul_busy_off", busy, 0);

        // Backpressure: MUL, ADD, ADD back-to-back, then a held ADD while full
        drive(1'b1, 6'b000111, 32'h2222_1111, 5'd1, 5'd2);
        step();
        check("bp_ready_a", bus.in_ready, 1);
        check("bp_we_a", rf_we, 0);
        drive(1'b1, 6'b000100, 32'h0000_0033, 5'd3, 5'd0);
        step();
        check_wr("bp_w1", 5'd1, 16'h1111);
        check("bp_ready_b", bus.in_ready, 1);
        drive(1'b1, 6'b000100, 32'h0000_0044, 5'd4, 5'd0);
        step();
        check_wr("bp_w2", 5'd2, 16'h2222);
        check("bp_ready_full", bus.in_ready, 0);
        drive(1'b1, 6'b000100, 32'h0000_0055, 5'd6, 5'd0);
        step();
        drive(1'b0, 6'd0, 32'd0, 5'd0, 5'd0);
        check_wr("bp_w3", 5'd3, 16'h0033);
        check("bp_ready_d", bus.in_ready, 1);
        step();
        check_wr("bp_w4", 5'd4, 16'h0044);
        step();
        check("bp_no_extra", rf_we, 0);
        check("bp_busy_off", busy, 0);

        // Illegal opcode dropped, SUB written
        drive(1'b1, 6'b111111, 32'h0000_9999, 5'd9, 5'd0);
        step();
        check("ill_we", rf_we, 0);
        check("ill_drop1", drop_cnt, 1);
        drive(1'b1, 6'b000101, 32'h0000_0001, 5'd7, 5'd0);
        step();
        drive(1'b0, 6'd0, 32'd0, 5'd0, 5'd0);
        check("sub_nowe_e0", rf_we, 0);
        check("sub_drop", drop_cnt, 1);
        step();
        check_wr("sub", 5'd7, 16'h0001);
        step();
        check("sub_we_off", rf_we, 0);

        // 300 illegal ops: counter saturates at 255
        drive(1'b1, 6'b111111, 32'd0, 5'd0, 5'd0);
        for (int i = 0; i < 253; i++) step();
        check("drop_254", drop_cnt, 254);
        for (int i = 0; i < 47; i++) step();
        drive(1'b0, 6'd0, 32'd0, 5'd0, 5'd0);
        check("drop_sat", drop_cnt, 255);
        check("drop_no_we", rf_we, 0);
        check("drop_busy", busy, 0);

        // Reset while the MUL low half is on the write port
        drive(1'b1, 6'b000111, 32'hDEAD_BEEF, 5'd8, 5'd9);
        step();
        drive(1'b0, 6'd0, 32'd0, 5'd0, 5'd0);
        step();
        check_wr("rstmul_lo", 5'd8, 16'hBEEF);
        reset = 1'b1;
        step();
        check("rstmul_we", rf_we, 0);
        check("rstmul_busy", busy, 0);
        check("rstmul_drop", drop_cnt, 0);
        check("rstmul_ready", bus.in_ready, 0);
`ifdef ALU_WRITEBACK_FWD_EN
        check("rstmul_fwd", fwd_valid, 0);
`endif
        reset = 1'b0;
        step();
        check("rel2_ready", bus.in_ready, 1);
        check("rel2_busy", busy, 0);
        check("rel2_drop", drop_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            check("rel2_no_hi", rf_we, 0);
            step();
        end

        // Opcode range edges: 6'h02 dropped, 6'h10 legal
        drive(1'b1, 6'h02, 32'h0000_7777, 5'd11, 5'd0);
        step();
        drive(1'b1, 6'h10, 32'h0000_0A0A, 5'd10, 5'd0);
        step();
        drive(1'b0, 6'd0, 32'd0, 5'd0, 5'd0);
        check("edge_drop", drop_cnt, 1);
        check("edge_nowe", rf_we, 0);
        step();
        check_wr("edge_op10", 5'd10, 16'h0A0A);
        step();
        check("edge_we_off", rf_we, 0);

`ifdef ALU_WRITEBACK_FWD_EN
        // Forwarding stays valid one cycle past the write
        step();
        check("fwd_idle", fwd_valid, 0);
        drive(1'b1, 6'b000100, 32'h0000_00FF, 5'd2, 5'd0);
        step();
        drive(1'b0, 6'd0, 32'd0, 5'd0, 5'd0);
        check("fwd_pre", fwd_valid, 0);
        step();
        check("fwd_v1", fwd_valid, 1);
        check("fwd_a1", fwd_addr, 2);
        check("fwd_d1", fwd_data, 16'h00FF);
        step();
        check("fwd_v2", fwd_valid, 1);
        check("fwd_a2", fwd_addr, 2);
        check("fwd_d2", fwd_data, 16'h00FF);
        check("fwd_we2", rf_we, 0);
        step();
        check("fwd_v3", fwd_valid, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
